// File: rtl/pll_fb_divider.sv
// Programmable PLL feedback divider with glitch-free ratio change at wrap and
// optional refclk-triggered pclk cycle snapshot (enabled by FB_DIV_SNAPSHOT_EN).
module pll_fb_divider #(
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 32,
  parameter int CNT_W     = 32
) (
  input  logic             pclk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] divn,
  input  logic             div_load,
  input  logic             refclk,
  output logic             fbclk,
  output logic             fb_edge,
  output logic             div_ack,
  output logic             div_err,
  output logic [DIV_W-1:0] active_div,
  output logic [CNT_W-1:0] cycle_snap,
  output logic             snap_valid
);

  localparam logic [DIV_W-1:0] RESET_RATIO = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] MIN_RATIO   = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] active_div_reg, active_div_next;
  logic [DIV_W-1:0] pending_div_reg, pending_div_next;
  logic             pending_reg, pending_next;
  logic             fbclk_reg, fbclk_next;
  logic             fb_edge_reg, fb_edge_next;
  logic             div_ack_reg, div_ack_next;
  logic             div_err_reg, div_err_next;
  logic             wrap;
  logic             load_ok;

  always_comb begin
    wrap             = (cnt_reg == '0);
    load_ok          = div_load && (divn >= MIN_RATIO);
    active_div_next  = active_div_reg;
    cnt_next         = cnt_reg - DIV_ONE;
    pending_next     = pending_reg;
    pending_div_next = pending_div_reg;
    div_ack_next     = 1'b0;
    div_err_next     = div_err_reg;
    fb_edge_next     = wrap;

    if (wrap) begin
      if (pending_reg) begin
        active_div_next = pending_div_reg;
      end
      cnt_next     = active_div_next - DIV_ONE;
      pending_next = 1'b0;
    end

    // A load on the wrap edge is staged after the swap above, so it waits a full period.
    if (div_load) begin
      if (load_ok) begin
        pending_next     = 1'b1;
        pending_div_next = divn;
        div_ack_next     = 1'b1;
        div_err_next     = 1'b0;
      end else begin
        div_err_next = 1'b1;
      end
    end

    fbclk_next = (cnt_next >= (active_div_next >> 1));
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg         <= RESET_RATIO - DIV_ONE;
      active_div_reg  <= RESET_RATIO;
      pending_reg     <= 1'b0;
      pending_div_reg <= '0;
      fbclk_reg       <= 1'b0;
      fb_edge_reg     <= 1'b0;
      div_ack_reg     <= 1'b0;
      div_err_reg     <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      active_div_reg  <= active_div_next;
      pending_reg     <= pending_next;
      pending_div_reg <= pending_div_next;
      fbclk_reg       <= fbclk_next;
      fb_edge_reg     <= fb_edge_next;
      div_ack_reg     <= div_ack_next;
      div_err_reg     <= div_err_next;
    end
  end

  assign fbclk      = fbclk_reg;
  assign fb_edge    = fb_edge_reg;
  assign div_ack    = div_ack_reg;
  assign div_err    = div_err_reg;
  assign active_div = active_div_reg;

`ifdef FB_DIV_SNAPSHOT_EN
  localparam int SYNC_STAGES = 2;

  logic [SYNC_STAGES-1:0] sync_reg, sync_next;
  logic                   ref_prev_reg;
  logic                   ref_rise;
  logic [CNT_W-1:0]       cycle_cnt_reg;
  logic [CNT_W-1:0]       cycle_snap_reg;
  logic                   snap_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = refclk;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign ref_rise = sync_reg[SYNC_STAGES-1] & ~ref_prev_reg;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      sync_reg       <= '0;
      ref_prev_reg   <= 1'b0;
      cycle_cnt_reg  <= '0;
      cycle_snap_reg <= '0;
      snap_valid_reg <= 1'b0;
    end else begin
      sync_reg       <= sync_next;
      ref_prev_reg   <= sync_reg[SYNC_STAGES-1];
      cycle_cnt_reg  <= cycle_cnt_reg + CNT_W'(1);
      snap_valid_reg <= ref_rise;
      if (ref_rise) begin
        cycle_snap_reg <= cycle_cnt_reg;
      end
    end
  end

  assign cycle_snap = cycle_snap_reg;
  assign snap_valid = snap_valid_reg;
`else
  logic unused_refclk;
  assign unused_refclk = refclk;
  assign cycle_snap    = '0;
  assign snap_valid    = 1'b0;
`endif

endmodule

// File: doc/pll_fb_divider.md
PLL_FB_DIVIDER -- requirements
Module: pll_fb_divider

Interface
REQ-001 Parameter DIV_W, default 16, width of divide-ratio ports.
REQ-002 Parameter RESET_DIV, default 32, divide ratio in force after reset; legal range 2..2^DIV_W-1.
REQ-003 Parameter CNT_W, default 32, width of free-running pclk cycle counter and snapshot.
REQ-004 pclk  in  1  DCO output clock; all state advances on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 divn  in  DIV_W  requested divide ratio, sampled only when div_load=1.
REQ-007 div_load  in  1  single-cycle request to stage divn.
REQ-008 refclk  in  1  reference clock, asynchronous to pclk, snapshot trigger only.
REQ-009 fbclk  out  1  divided feedback clock to the TDC, registered.
REQ-010 fb_edge  out  1  one-pclk pulse marking each divider wrap, registered.
REQ-011 div_ack  out  1  one-pclk pulse: divn accepted into pending register.
REQ-012 div_err  out  1  sticky flag: illegal divn rejected.
REQ-013 active_div  out  DIV_W  divide ratio currently in force.
REQ-014 cycle_snap  out  CNT_W  pclk cycle count captured at the latest refclk rising edge.
REQ-015 snap_valid  out  1  one-pclk pulse: cycle_snap updated.

Function
REQ-016 Down-counter cnt shall decrement by 1 each pclk edge; on the edge where cnt==0 it shall reload to N-1, N being the ratio in force from that edge on.
REQ-017 At a reload edge, a pending ratio shall become active_div and clear pending; otherwise active_div is unchanged. Ratio changes therefore only take effect at wrap (glitch-free).
REQ-018 fb_edge shall be 1 for exactly the cycle following each reload edge; fb_edge period = active_div pclk cycles.
REQ-019 fbclk shall be registered as (next cnt >= next active_div/2, floor division): high ceil(N/2) cycles, low floor(N/2) cycles per period, rising coincident with fb_edge.
REQ-020 div_load with 2 <= divn: pending_div <= divn, pending <= 1, div_ack pulses in the following cycle, div_err cleared.
REQ-021 div_load with divn < 2: request discarded, pending/pending_div unchanged, div_ack stays 0, div_err set to 1 and held.
REQ-022 Back-to-back or repeated loads before a wrap: last accepted value wins; each accepted load produces its own div_ack.
REQ-023 div_load on the same edge as a reload: the reload uses the previously pending (or active) ratio; the new divn becomes pending and applies at the following wrap.
REQ-024 Free-running counter cycle_cnt (CNT_W) shall increment every pclk edge, wrapping modulo 2^CNT_W.
REQ-025 refclk shall pass a 2-flop synchroniser into pclk; a rising edge of the synchronised signal shall capture cycle_cnt into cycle_snap and pulse snap_valid one cycle; snap_valid rises at the 3rd pclk edge at which refclk is sampled high.

Reset
REQ-026 resetn low shall immediately force: cnt=RESET_DIV-1, active_div=RESET_DIV, pending=0, pending_div=0, fbclk=0, fb_edge=0, div_ack=0, div_err=0, cycle_cnt=0, cycle_snap=0, snap_valid=0, synchroniser flops=0.
REQ-027 Reset asserted mid-period shall abandon the period and any pending ratio; the first fb_edge after release occurs RESET_DIV pclk edges after release.

Configuration
REQ-028 Macro FB_DIV_SNAPSHOT_EN defined: REQ-024/REQ-025 logic compiled in.
REQ-029 Macro FB_DIV_SNAPSHOT_EN undefined: synchroniser and counters omitted, cycle_snap tied to 0, snap_valid tied to 0, refclk unused; all other behaviour identical.

Verification
REQ-030 Reset release, RESET_DIV=32, no loads -> fb_edge every 32 cycles, fbclk 16 high / 16 low, active_div=32.
REQ-031 div_load divn=5 at cnt=20 -> div_ack next cycle, active_div stays 32 until wrap, then 5; fbclk 3 high / 2 low, fb_edge period 5.
REQ-032 div_load divn=1 -> div_err=1, no div_ack, period unchanged; later divn=8 load -> div_err=0, div_ack, period 8 after next wrap.
REQ-033 Loads 10 then 12 on consecutive cycles before wrap -> two div_ack pulses, active_div=12 after wrap; load coincident with wrap -> applied one period later.
REQ-034 resetn pulsed low mid-period with pending=1 -> all outputs at reset values asynchronously; pending ratio lost; first fb_edge 32 edges after release.
REQ-035 With FB_DIV_SNAPSHOT_EN, refclk period = 32 pclk periods -> successive cycle_snap values differ by exactly 32, one snap_valid per refclk rise; without macro -> snap_valid and cycle_snap remain 0.
